// File: rtl/reg_bcd_converter.sv
// Sequential binary-to-BCD converter: samples a 32-bit value and produces
// value mod 1000 as three BCD digits via a 32-step double dabble engine.
module reg_bcd_converter #(
  parameter int unsigned AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic        overflow
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_next;
  logic [31:0] shift;
  logic [11:0] scratch;
  logic [10:0] adj;
  logic [11:0] scratch_next;
  logic [4:0]  count;
  logic        ovf_pend;
  logic        auto_tick;
  logic        req;

  generate
    if (AUTO_PERIOD == 0) begin : g_no_auto
      assign auto_tick = 1'b0;
    end else begin : g_auto
      localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      logic [CW-1:0] auto_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          auto_cnt <= '0;
        end else if (auto_cnt == CW'(AUTO_PERIOD - 1)) begin
          auto_cnt <= '0;
        end else begin
          auto_cnt <= auto_cnt + CW'(1);
        end
      end

      assign auto_tick = (auto_cnt == CW'(AUTO_PERIOD - 1));
    end
  endgenerate

  assign req  = start | auto_tick;
  assign busy = (state == CONV);

  // Hundreds digit keeps only 3 bits: its top bit is shifted out and dropped,
  // which is what turns the result into value mod 1000.
  always_comb begin
    adj        = '0;
    adj[3:0]   = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
    adj[7:4]   = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
    adj[10:8]  = scratch[10:8] + ((scratch[11:8] >= 4'd5) ? 3'd3 : 3'd0);
    scratch_next = {adj, shift[31]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = CONV;
      CONV:    if (count == 5'd31) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      scratch  <= '0;
      count    <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            shift    <= value;
            scratch  <= '0;
            count    <= '0;
            ovf_pend <= (value > 32'd999);
          end
        end
        CONV: begin
          scratch <= scratch_next;
          shift   <= {shift[30:0], 1'b0};
          count   <= count + 5'd1;
          if (count == 5'd31) begin
            bcd      <= scratch_next;
            overflow <= ovf_pend;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bcd_converter.sv
// Scoreboard bench for reg_bcd_converter: stimulus pushes expected results,
// negedge monitors pop and compare on every done pulse.
module tb_reg_bcd_converter;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] value;
  logic        busy, done, overflow;
  logic [11:0] bcd;

  logic        rst_a;
  logic [31:0] value_a;
  logic        busy_a, done_a, overflow_a;
  logic [11:0] bcd_a;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];
  logic [12:0] shown     = '0;
  int          done_seen = 0;
  int          issued    = 0;
  int          busy_run  = 0;
  logic        prev_busy = 1'b0;

  logic [12:0] exp_a;
  int          a_dones   = 0;
  int          a_last    = -1;
  int          cyc       = 0;
  logic        auto_done = 1'b0;

  always #5 clk = ~clk;

  reg_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  reg_bcd_converter #(.AUTO_PERIOD(40)) dut_auto (
    .clk(clk), .rst(rst_a), .start(1'b0), .value(value_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(overflow_a)
  );

  // Reference: {overflow, hundreds, tens, ones} of value mod 1000.
  function automatic logic [12:0] refConv(input logic [31:0] v);
    int unsigned m;
    m = v % 32'd1000;
    return {v > 32'd999, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_result", {overflow, bcd}, 13'h0);
      checkOutput("reset_busy_done", {11'b0, busy, done}, 13'h0);
      exp_q.delete();
      shown     = '0;
      busy_run  = 0;
      prev_busy = 1'b0;
    end else begin
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got bcd %h with no pending request", bcd);
        end else begin
          shown = exp_q.pop_front();
          checkOutput("result", {overflow, bcd}, shown);
        end
        if (prev_busy) checkOutput("busy_len", 13'(busy_run), 13'd32);
      end else begin
        checkOutput("hold", {overflow, bcd}, shown);
      end
      if (busy) busy_run = prev_busy ? busy_run + 1 : 1;
      prev_busy = busy;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_a && done_a) begin
      a_dones++;
      checkOutput("auto_result", {overflow_a, bcd_a}, exp_a);
      if (a_last >= 0) checkOutput("auto_period", 13'(cyc - a_last), 13'd40);
      a_last = cyc;
    end
  end

  task automatic applyStimulus(input logic [31:0] v);
    @(posedge clk); #1;
    value = v;
    start = 1'b1;
    exp_q.push_back(refConv(v));
    issued++;
    @(posedge clk); #1;
    start = 1'b0;
    value = $urandom;
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (done_seen < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_seen < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: done count %0d, required %0d", done_seen, target);
    end
  endtask

  initial begin
    int n;
    rst_a   = 1'b1;
    value_a = 32'd123;
    exp_a   = refConv(32'd123);
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    n = 0;
    while (a_dones < 3 && n < 300) begin @(negedge clk); #1; n++; end
    value_a = 32'd456;
    exp_a   = refConv(32'd456);
    n = 0;
    while (a_dones < 5 && n < 300) begin @(negedge clk); #1; n++; end
    if (a_dones < 5) begin
      checks++;
      failures++;
      $display("[TB] FAIL auto_timeout: got %0d auto dones, required 5", a_dones);
    end
    auto_done = 1'b1;
  end

  initial begin
    logic [31:0] directed [5];
    logic [31:0] v;
    int n;
    directed = '{32'd12, 32'd999, 32'd1000, 32'hFFFF_FFFF, 32'd0};
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    foreach (directed[i]) begin
      applyStimulus(directed[i]);
      waitDone(issued);
    end

    // Start pulse mid-conversion must be dropped.
    applyStimulus(32'd345);
    repeat (9) @(posedge clk);
    #1 value = 32'd678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waitDone(issued);
    repeat (40) @(posedge clk);

    // Reset mid-conversion aborts with no done.
    applyStimulus(32'd500);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    issued--;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    applyStimulus(32'd77);
    waitDone(issued);

    // Held start gives back-to-back conversions 33 clocks apart.
    @(posedge clk); #1;
    value = 32'd2468;
    start = 1'b1;
    exp_q.push_back(refConv(32'd2468));
    issued++;
    @(posedge clk); #1;
    value = 32'd531;
    exp_q.push_back(refConv(32'd531));
    issued++;
    repeat (33) @(posedge clk);
    #1 start = 1'b0;
    waitDone(issued);

    for (int i = 0; i < 10; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1999));
      applyStimulus(v);
      waitDone(issued);
    end

    n = 0;
    while (!auto_done && n < 2000) begin @(negedge clk); n++; end
    checkOutput("auto_finished", {12'b0, auto_done}, 13'h1);
    repeat (40) @(posedge clk);
    checkOutput("done_count", 13'(done_seen), 13'(issued));
    checkOutput("queue_empty", 13'(exp_q.size()), 13'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bcd_converter.md
# reg_bcd_converter

Sequential binary-to-BCD converter between the CPU register-file taps and the `seven_segments` display decoder. It samples a 32-bit register value on request, or periodically when auto-sampling is enabled. It converts the sample to three BCD digits with an iterative shift-and-add-3 (double dabble) engine. The previous result is held stable on the outputs while a conversion runs, so the 3-digit display never shows intermediate values.

## Interface
- `AUTO_PERIOD`, default 0: auto-sample interval in clocks. 0 disables auto-sampling; any nonzero value N generates one internal request every N clocks.
- `clk` in 1: single system clock (the divided CPU clock); all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: conversion request, sampled on rising edge; level, not edge-detected.
- `value` in 32: unsigned register value to convert; captured only on the accept edge.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse; new `bcd`/`overflow` valid.
- `bcd` out 12: `[11:8]` hundreds, `[7:4]` tens, `[3:0]` ones.
- `overflow` out 1: captured value exceeded 999.

## Operation
- States: IDLE and CONV.
- Request: `req = start | auto_tick`. `auto_tick` is the wrap of a free-running counter 0..AUTO_PERIOD-1 that runs regardless of state; it is never asserted when AUTO_PERIOD=0.
- IDLE with `req`=1 (accept edge):
  - shift register <= `value`
  - scratch (12-bit BCD) <= 0
  - iteration count <= 0
  - `ovf_pend` <= (`value` > 999)
  - state -> CONV
- IDLE with `req`=0: hold.
- CONV, each edge: first, every scratch digit >= 5 gets +3 (4-bit, no carry between digits). Then {scratch, shift} shifts left 1 bit; the scratch MSB is discarded; count increments.
- CONV with count==31 on that edge: state -> IDLE; `bcd` <= final scratch; `overflow` <= `ovf_pend`; `done` <= 1.
- Arithmetic result: `bcd` = `value` mod 1000 in BCD, because bits leaving the hundreds digit are dropped. `overflow` flags any truncation.
- Requests while in CONV (`start` or `auto_tick`) are dropped, not queued. `value` changes during CONV have no effect.
- `bcd` and `overflow` change only on the completion edge; they hold the prior result otherwise.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=12'h000, `overflow`=0, state IDLE, auto counter 0. Asserting `rst` mid-conversion aborts it immediately; outputs return to reset values.
- `busy`: combinational from state (CONV). High for exactly 32 cycles, starting the cycle after the accept edge.
- Latency: accept at edge E. Iterations run on edges E+1..E+32. `done`=1 and the new `bcd` appear in the cycle after edge E+32; `done` is low again after E+33.
- Back-to-back: `start` held high re-accepts at edge E+33, since IDLE lasts only the E+32 -> E+33 cycle. The throughput is one conversion per 33 clocks.
- Auto mode: with AUTO_PERIOD < 33, some ticks fall in CONV and are dropped. Results stay correct.
- Simultaneous `start` and `auto_tick` in IDLE produce a single conversion.
- No combinational path from `value` or `start` to any output.

## Test plan
- Reset, then `value`=12 with a 1-cycle `start` -> `busy` high 32 cycles; `done` pulse one cycle later; `bcd`=12'h012; `overflow`=0.
- `value`=999 -> `bcd`=12'h999, `overflow`=0. Then `value`=1000 -> `bcd`=12'h000, `overflow`=1.
- `value`=32'hFFFF_FFFF -> `bcd`=12'h295, `overflow`=1. `value`=0 -> `bcd`=12'h000, `overflow`=0.
- Start 345, then pulse `start` with `value`=678 at cycle 10 of CONV -> exactly one `done`; `bcd`=12'h345. `bcd` holds the prior result (12'h000 after reset) until completion.
- Start 500, assert `rst` at cycle 15 of CONV -> `busy`=0, `bcd`=0, and no `done`. Next `start` with 77 -> `bcd`=12'h077 after 32 cycles.
- AUTO_PERIOD=40, `value`=123, `start` tied 0 -> a `done` pulse every 40 clocks with `bcd`=12'h123. Change `value` to 456 -> the next completed conversion shows 12'h456.
